// File: rtl/sr_cmd_sequencer_if.sv
// Button/latch-drive bundle between the SR command sequencer and its surroundings.
//   set_btn, rst_btn : raw pushbutton levels (asynchronous, may bounce)
//   S, R, L_en       : drive to the gated SR latch S, R and gate-enable pins
//   busy             : a command sequence is in progress
//   conflict         : 1-cycle pulse, simultaneous set/reset requests were dropped
//   q_model          : expected latch Q after the last completed command
// slave  : the sequencer side (buttons in, latch drive out)
// master : the environment side (buttons out, latch drive in)
interface sr_cmd_sequencer_if;
  logic set_btn;
  logic rst_btn;
  logic S;
  logic R;
  logic L_en;
  logic busy;
  logic conflict;
  logic q_model;

  modport master (
    output set_btn, rst_btn,
    input  S, R, L_en, busy, conflict, q_model
  );

  modport slave (
    input  set_btn, rst_btn,
    output S, R, L_en, busy, conflict, q_model
  );
endinterface

// File: rtl/sr_cmd_sequencer.sv
// Upstream driver for a gated SR latch. Synchronises and debounces the set and
// reset pushbuttons, and turns each request into a conflict-free
// SETUP / PULSE / HOLD sequence on S, R and L_en. After power-up an
// initialising reset command is run. q_model tracks the value the latch holds.
// Ports:
//   Clk   : system clock, rising edge
//   Rst_n : asynchronous active-low reset (aborts any sequence, L_en drops at once)
//   bus   : sr_cmd_sequencer_if.slave (buttons in, latch drive and status out)
module sr_cmd_sequencer #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 3
) (
  input logic                 Clk,
  input logic                 Rst_n,
  sr_cmd_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } state_t;

  // Index 0 = set button, index 1 = reset button.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       req;
  logic [CNT_W-1:0] deb_cnt [2];

  assign raw = {bus.rst_btn, bus.set_btn};

  // Two-flop synchroniser, then a level debouncer that emits a 1-cycle
  // request on the rising edge of the debounced level only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      req   <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        req[i] <= 1'b0;
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
            req[i]     <= sync2[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  state_t           state, state_nxt;
  logic             cmd, cmd_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             pend_cmd, pend_cmd_nxt;
  logic             q_model_q, q_model_nxt;
  logic             s_q, s_nxt;
  logic             r_q, r_nxt;
  logic             len_q, len_nxt;
  logic             busy_q, busy_nxt;
  logic             conflict_q, conflict_nxt;
  logic             req_both;
  logic             req_one;
  logic             req_cmd;

  // State register; outputs are registered copies of the next-state decode.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= ST_INIT;
      cmd        <= 1'b0;
      hold_cnt   <= '0;
      pend_vld   <= 1'b0;
      pend_cmd   <= 1'b0;
      q_model_q  <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      len_q      <= 1'b0;
      busy_q     <= 1'b1;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      cmd        <= cmd_nxt;
      hold_cnt   <= hold_cnt_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_cmd   <= pend_cmd_nxt;
      q_model_q  <= q_model_nxt;
      s_q        <= s_nxt;
      r_q        <= r_nxt;
      len_q      <= len_nxt;
      busy_q     <= busy_nxt;
      conflict_q <= conflict_nxt;
    end
  end

  // Next-state, pending-slot and output decode.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd;
    hold_cnt_nxt = hold_cnt;
    pend_vld_nxt = pend_vld;
    pend_cmd_nxt = pend_cmd;
    q_model_nxt  = q_model_q;
    conflict_nxt = 1'b0;
    s_nxt        = 1'b0;
    r_nxt        = 1'b0;
    len_nxt      = 1'b0;
    busy_nxt     = 1'b1;

    req_both = req[0] & req[1];
    req_one  = req[0] ^ req[1];
    req_cmd  = req[0];

    case (state)
      ST_INIT: begin
        cmd_nxt      = 1'b0;
        hold_cnt_nxt = '0;
        state_nxt    = ST_PULSE;
      end
      ST_IDLE: begin
        if (pend_vld) begin
          cmd_nxt      = pend_cmd;
          pend_vld_nxt = 1'b0;
          state_nxt    = ST_SETUP;
        end else if (req_one) begin
          cmd_nxt   = req_cmd;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        hold_cnt_nxt = '0;
        state_nxt    = ST_PULSE;
      end
      ST_PULSE: begin
        if (hold_cnt == HOLD_MAX) begin
          state_nxt = ST_HOLD;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        q_model_nxt = cmd;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase

    // Single pending slot: latest single request wins; a simultaneous pair
    // is dropped and also clears anything waiting. A single request seen in
    // IDLE only queues when a pending command is being launched this cycle.
    if (req_both) begin
      conflict_nxt = 1'b1;
      if (state != ST_IDLE) pend_vld_nxt = 1'b0;
    end else if (req_one && (state != ST_IDLE || pend_vld)) begin
      pend_vld_nxt = 1'b1;
      pend_cmd_nxt = req_cmd;
    end

    // S/R only move on transitions where L_en is low on both sides.
    case (state_nxt)
      ST_INIT: r_nxt = 1'b1;
      ST_IDLE: busy_nxt = 1'b0;
      ST_SETUP, ST_HOLD: begin
        s_nxt = cmd_nxt;
        r_nxt = ~cmd_nxt;
      end
      ST_PULSE: begin
        s_nxt   = cmd_nxt;
        r_nxt   = ~cmd_nxt;
        len_nxt = 1'b1;
      end
      default: busy_nxt = 1'b1;
    endcase
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.L_en     = len_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;
  assign bus.q_model  = q_model_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Self-checking bench for sr_cmd_sequencer (DEB_CYCLES=4, HOLD_CYCLES=2).
module tb_sr_cmd_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sr_cmd_sequencer_if bus ();

  sr_cmd_sequencer #(
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (2),
    .CNT_W       (3)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Output monitor: counts commands (L_en rising), conflict pulses and
  // protocol violations (S=R=1, or S/R moving while L_en stays high).
  int   n_cmd_set = 0;
  int   n_cmd_rst = 0;
  int   n_conf    = 0;
  int   n_viol    = 0;
  logic len_p     = 1'b0;
  logic s_p       = 1'b0;
  logic r_p       = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.S && bus.R) n_viol++;
      if (bus.L_en && len_p && (bus.S != s_p || bus.R != r_p)) n_viol++;
      if (bus.L_en && !len_p) begin
        if (bus.S) n_cmd_set++;
        else if (bus.R) n_cmd_rst++;
      end
      if (bus.conflict) n_conf++;
    end
    len_p = bus.L_en;
    s_p   = bus.S;
    r_p   = bus.R;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] set_pat;
    logic [15:0] rst_pat;
    int          exp_set;
    int          exp_rst;
    int          exp_conf;
    int          exp_q;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int   b_set, b_rst, b_conf, lat;
    logic found;

    // Patterns are applied LSB first, one bit per cycle, then both released.
    vecs[0] = '{16'hFFFF, 16'h0000, 1, 0, 0, 1}; // clean set
    vecs[1] = '{16'hFFFF, 16'h0000, 1, 0, 0, 1}; // set again, re-executed
    vecs[2] = '{16'h0000, 16'hFFFF, 0, 1, 0, 0}; // clean reset
    vecs[3] = '{16'hFFF5, 16'h0000, 1, 0, 0, 1}; // bouncing set
    vecs[4] = '{16'h0007, 16'h0000, 0, 0, 0, 1}; // 3-cycle glitch, ignored
    vecs[5] = '{16'h0000, 16'h000F, 0, 1, 0, 0}; // exactly DEB_CYCLES wide
    vecs[6] = '{16'hFFFF, 16'hFFFF, 0, 0, 1, 0}; // same-cycle conflict in IDLE
    vecs[7] = '{16'hFFFF, 16'hFFFC, 1, 1, 0, 0}; // reset during set PULSE
    vecs[8] = '{16'hFFFE, 16'hFFFF, 1, 1, 0, 1}; // set during reset SETUP

    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;

    // Reset values, then the power-up reset command.
    repeat (2) @(posedge clk);
    #1;
    check("rst_S", int'(bus.S), 0);
    check("rst_R", int'(bus.R), 0);
    check("rst_L_en", int'(bus.L_en), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_conflict", int'(bus.conflict), 0);
    check("rst_q_model", int'(bus.q_model), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("init_c1_R", int'(bus.R), 1);
    check("init_c1_L_en", int'(bus.L_en), 1);
    check("init_c1_S", int'(bus.S), 0);
    tick();
    check("init_c2_L_en", int'(bus.L_en), 1);
    tick();
    check("init_hold_L_en", int'(bus.L_en), 0);
    check("init_hold_R", int'(bus.R), 1);
    check("init_hold_busy", int'(bus.busy), 1);
    tick();
    check("init_done_busy", int'(bus.busy), 0);
    check("init_done_R", int'(bus.R), 0);
    check("init_done_q", int'(bus.q_model), 0);

    // Clean set press: exact latency and sequence shape.
    b_set = n_cmd_set;
    @(negedge clk) bus.set_btn = 1'b1;
    lat   = 0;
    found = 1'b0;
    for (int c = 1; c <= 12 && !found; c++) begin
      tick();
      if (bus.S) begin
        found = 1'b1;
        lat   = c;
      end
    end
    check("set_latency", lat, 7);
    check("setup_L_en", int'(bus.L_en), 0);
    check("setup_R", int'(bus.R), 0);
    tick();
    check("pulse1_L_en", int'(bus.L_en), 1);
    check("pulse1_S", int'(bus.S), 1);
    tick();
    check("pulse2_L_en", int'(bus.L_en), 1);
    tick();
    check("hold_L_en", int'(bus.L_en), 0);
    check("hold_S", int'(bus.S), 1);
    check("hold_busy", int'(bus.busy), 1);
    tick();
    check("set_done_busy", int'(bus.busy), 0);
    check("set_done_S", int'(bus.S), 0);
    check("set_done_q", int'(bus.q_model), 1);
    repeat (9) tick();
    @(negedge clk) bus.set_btn = 1'b0;
    repeat (30) tick();
    check("set_single_cmd", n_cmd_set - b_set, 1);

    // Table-driven patterns, each starting and ending in IDLE.
    for (int v = 0; v < 9; v++) begin
      b_set  = n_cmd_set;
      b_rst  = n_cmd_rst;
      b_conf = n_conf;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        bus.set_btn = vecs[v].set_pat[i];
        bus.rst_btn = vecs[v].rst_pat[i];
      end
      @(negedge clk);
      bus.set_btn = 1'b0;
      bus.rst_btn = 1'b0;
      repeat (30) tick();
      check($sformatf("vec%0d_set_cmds", v), n_cmd_set - b_set, vecs[v].exp_set);
      check($sformatf("vec%0d_rst_cmds", v), n_cmd_rst - b_rst, vecs[v].exp_rst);
      check($sformatf("vec%0d_conflicts", v), n_conf - b_conf, vecs[v].exp_conf);
      check($sformatf("vec%0d_q_model", v), int'(bus.q_model), vecs[v].exp_q);
    end

    // Rst_n pulsed low during a set PULSE.
    @(negedge clk) bus.set_btn = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (bus.L_en) found = 1'b1;
    end
    check("abort_reached_pulse", int'(found), 1);
    #2;
    rst_n       = 1'b0;
    bus.set_btn = 1'b0;
    #1;
    check("abort_L_en_async", int'(bus.L_en), 0);
    check("abort_S", int'(bus.S), 0);
    check("abort_busy", int'(bus.busy), 1);
    check("abort_q_model", int'(bus.q_model), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("reinit_R", int'(bus.R), 1);
    check("reinit_L_en", int'(bus.L_en), 1);
    tick();
    tick();
    check("reinit_hold_L_en", int'(bus.L_en), 0);
    tick();
    check("reinit_busy", int'(bus.busy), 0);
    check("reinit_q_model", int'(bus.q_model), 0);
    repeat (20) tick();
    check("reinit_no_stray_set", int'(bus.q_model), 0);

    check("protocol_violations", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
